motor_ramp_sequencer: RTL and testbench
=======================================

MOTOR_RAMP_SEQUENCER -- requirements
Module: MOTOR_RAMP_SEQUENCER

Interface
REQ-001 SHALL have parameter resolution_bits, default 12, giving the POWER/TARGET width.
REQ-002 SHALL have parameter ramp_div, default 1000, giving clock cycles per ramp step (>=2).
REQ-003 SHALL have parameter ramp_step, default 8, giving POWER LSBs per ramp step (>=1).
REQ-004 SHALL have parameter settle_cycles, default 256, giving the zero-power dwell before a modulation change (>=1).
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port ENABLE, input, 1 bit: run request.
REQ-008 SHALL have port FAULT, input, 1 bit: immediate stop request.
REQ-009 SHALL have port TARGET, input, resolution_bits: power setpoint.
REQ-010 SHALL have port MOD_REQ, input, 1 bit: requested modulation (1 = vector, 0 = sine).
REQ-011 SHALL have port DELAY_CFG, input, 7 bits: requested dead-time code.
REQ-012 SHALL have port UMIN_CFG, input, 7 bits: requested minimum amplitude.
REQ-013 SHALL have port POWER, output, resolution_bits: ramped power command to the motor controller.
REQ-014 SHALL have port MOD_DELAY_UMIN, output, 16 bits: {mod_cur, delay_cur[6:0], umin_cur[6:0], 1'b0}.
REQ-015 SHALL have port STATE, output, 3 bits: IDLE=0, RAMP=1, RUN=2, RAMP_DOWN=3, SETTLE=4, FAULT=5.
REQ-016 SHALL have port AT_TARGET, output, 1 bit: high only in RUN.

Function
REQ-017 SHALL give FAULT=1 top priority: from any state, next cycle STATE=FAULT and POWER=0.
REQ-018 SHALL leave FAULT for IDLE only when FAULT=0 and ENABLE=0 are sampled together.
REQ-019 SHALL hold POWER=0 in IDLE, SETTLE and FAULT.
REQ-020 SHALL use a prescaler that clears on every state entry and ticks once per ramp_div cycles, with the first tick ramp_div cycles after entry.
REQ-021 SHALL, in RAMP, on each tick move POWER toward the live TARGET by ramp_step, clamped so it never overshoots (arithmetic in resolution_bits+1 bits, no wrap).
REQ-022 SHALL go from RAMP to RUN on the cycle after POWER equals TARGET.
REQ-023 SHALL go from RUN to RAMP when TARGET differs from POWER.
REQ-024 SHALL go from RAMP or RUN to RAMP_DOWN when ENABLE=0 or MOD_REQ differs from mod_cur.
REQ-025 SHALL, in RAMP_DOWN, decrement POWER by ramp_step per tick, saturating at 0, and enter SETTLE on the cycle after POWER reaches 0.
REQ-026 SHALL go from IDLE with ENABLE=1 to SETTLE if MOD_REQ differs from mod_cur, otherwise to RAMP.
REQ-027 SHALL count settle_cycles cycles in SETTLE, then in one cycle load mod_cur from MOD_REQ and go to RAMP if ENABLE=1, else IDLE.
REQ-028 SHALL load delay_cur and umin_cur from DELAY_CFG and UMIN_CFG only while STATE is IDLE or SETTLE; they are frozen otherwise.
REQ-029 SHALL change mod_cur only at the end of SETTLE, never while POWER is nonzero.
REQ-030 SHALL register all outputs, with no combinational input-to-output path.

Reset
REQ-031 SHALL, while RST=1, force on the next edge: POWER=0, STATE=IDLE, mod_cur=1, delay_cur=7'h7F, umin_cur=0, prescaler=0, settle counter=0; RST overrides FAULT.
REQ-032 SHALL treat RST mid-ramp as an immediate drop of POWER to 0 with no ramp-down.

Verification (ramp_div=4, ramp_step=16, settle_cycles=8)
REQ-033 SHALL cover: reset, ENABLE=1, TARGET=40 -> STATE=RAMP; POWER 16, 32, 40 at 4-cycle spacing; then RUN with AT_TARGET=1.
REQ-034 SHALL cover: in RUN at 40, ENABLE=0 -> RAMP_DOWN; POWER 24, 8, 0; SETTLE for 8 cycles; then IDLE.
REQ-035 SHALL cover: in RUN, MOD_REQ 1->0 -> ramp to 0, SETTLE, then MOD_DELAY_UMIN[15]=0; re-ramp to TARGET while bit 15 never changes with POWER!=0.
REQ-036 SHALL cover: FAULT pulse during RAMP at POWER=32 -> POWER=0 next cycle, STATE=5; it stays 5 while ENABLE=1 even after FAULT=0; ENABLE=0 -> IDLE.
REQ-037 SHALL cover: DELAY_CFG changed in RUN -> MOD_DELAY_UMIN[14:8] unchanged until the next SETTLE/IDLE; after reset the field reads 7'h7F.
REQ-038 SHALL cover: TARGET=4095 with ramp_step=16 -> POWER clamps at exactly 4095, with no wrap to 0.

Source files
------------

// File: rtl/motor_ramp_sequencer_if.sv
// motor_ramp_sequencer_if: run request, setpoint and config in; ramped power command and status out
interface motor_ramp_sequencer_if #(parameter int resolution_bits = 12);
    logic                       ENABLE;
    logic                       FAULT;
    logic [resolution_bits-1:0] TARGET;
    logic                       MOD_REQ;
    logic [6:0]                 DELAY_CFG;
    logic [6:0]                 UMIN_CFG;
    logic [resolution_bits-1:0] POWER;
    logic [15:0]                MOD_DELAY_UMIN;
    logic [2:0]                 STATE;
    logic                       AT_TARGET;
    modport master (
        output ENABLE, FAULT, TARGET, MOD_REQ, DELAY_CFG, UMIN_CFG,
        input  POWER, MOD_DELAY_UMIN, STATE, AT_TARGET
    );
    modport slave (
        input  ENABLE, FAULT, TARGET, MOD_REQ, DELAY_CFG, UMIN_CFG,
        output POWER, MOD_DELAY_UMIN, STATE, AT_TARGET
    );
endinterface

// File: rtl/motor_ramp_sequencer.sv
// motor_ramp_sequencer: ramps motor power toward a setpoint; modulation only changes after a zero-power settle
module motor_ramp_sequencer #(
    parameter int resolution_bits = 12,
    parameter int ramp_div        = 1000,
    parameter int ramp_step       = 8,
    parameter int settle_cycles   = 256
) (
    input logic                  CLK,
    input logic                  RST,
    motor_ramp_sequencer_if.slave bus
);
    localparam int pres_w = $clog2(ramp_div);
    localparam int cnt_w  = $clog2(settle_cycles + 1);
    localparam logic [resolution_bits-1:0] step_n = resolution_bits'(ramp_step);
    localparam logic [resolution_bits:0]   step_w = (resolution_bits + 1)'(ramp_step);
    typedef enum logic [2:0] {
        IDLE = 3'd0, RAMP = 3'd1, RUN = 3'd2, RAMP_DOWN = 3'd3, SETTLE = 3'd4, FAULTED = 3'd5
    } state_t;
    state_t                     state, state_nxt;
    logic [resolution_bits-1:0] power, power_nxt, toward, drop;
    logic [resolution_bits:0]   pw_x, tg_x;
    logic [pres_w-1:0]          presc;
    logic [cnt_w-1:0]           settle_cnt;
    logic                       mod_cur, at_target, tick, settle_done, mod_chg, leave;
    logic [6:0]                 delay_cur, umin_cur;
    assign pw_x        = {1'b0, power};
    assign tg_x        = {1'b0, bus.TARGET};
    assign tick        = presc == pres_w'(ramp_div - 1);
    assign settle_done = settle_cnt == cnt_w'(settle_cycles - 1);
    assign mod_chg     = bus.MOD_REQ != mod_cur;
    assign leave       = !bus.ENABLE || mod_chg;
    // one ramp step toward the live target; comparisons are one bit wider so the step never wraps or overshoots
    assign toward = (tg_x > pw_x) ? ((pw_x + step_w >= tg_x) ? bus.TARGET : power + step_n)
                                  : ((pw_x >= tg_x + step_w) ? power - step_n : bus.TARGET);
    assign drop   = (pw_x >= step_w) ? power - step_n : '0;
    // state register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end
    // next-state decode; a fault request overrides every other transition
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = bus.ENABLE ? (mod_chg ? SETTLE : RAMP) : IDLE;
            RAMP:      state_nxt = leave ? RAMP_DOWN : (power == bus.TARGET ? RUN : RAMP);
            RUN:       state_nxt = leave ? RAMP_DOWN : (power != bus.TARGET ? RAMP : RUN);
            RAMP_DOWN: state_nxt = (power == '0) ? SETTLE : RAMP_DOWN;
            SETTLE:    state_nxt = settle_done ? (bus.ENABLE ? RAMP : IDLE) : SETTLE;
            FAULTED:   state_nxt = bus.ENABLE ? FAULTED : IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (bus.FAULT) state_nxt = FAULTED;
    end
    // power command: zero outside the ramping states, moves only on a prescaler tick
    always_comb begin
        power_nxt = power;
        if (bus.FAULT || state == IDLE || state == SETTLE || state == FAULTED) power_nxt = '0;
        else if (tick && state == RAMP && state_nxt == RAMP)                 power_nxt = toward;
        else if (tick && state == RAMP_DOWN)                                 power_nxt = drop;
    end
    // datapath registers: prescaler and settle counter restart on every state change
    always_ff @(posedge CLK) begin
        if (RST) begin
            power      <= '0;
            at_target  <= 1'b0;
            presc      <= '0;
            settle_cnt <= '0;
            mod_cur    <= 1'b1;
            delay_cur  <= 7'h7F;
            umin_cur   <= 7'h00;
        end else begin
            power      <= power_nxt;
            at_target  <= state_nxt == RUN;
            presc      <= (state_nxt != state || tick) ? '0 : presc + 1'b1;
            settle_cnt <= (state_nxt != state) ? '0 : (state == SETTLE ? settle_cnt + 1'b1 : settle_cnt);
            if (state == SETTLE && settle_done && !bus.FAULT) mod_cur <= bus.MOD_REQ;
            if (state == IDLE || state == SETTLE) begin
                delay_cur <= bus.DELAY_CFG;
                umin_cur  <= bus.UMIN_CFG;
            end
        end
    end
    assign bus.POWER          = power;
    assign bus.STATE          = state;
    assign bus.AT_TARGET      = at_target;
    assign bus.MOD_DELAY_UMIN = {mod_cur, delay_cur, umin_cur, 1'b0};
endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// tb_motor_ramp_sequencer: directed vector table plus hand sequences for the ramp sequencer
module tb_motor_ramp_sequencer;
    localparam int RB = 12;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;
    motor_ramp_sequencer_if #(.resolution_bits(RB)) bus ();
    motor_ramp_sequencer #(
        .resolution_bits(RB), .ramp_div(4), .ramp_step(16), .settle_cycles(8)
    ) dut (.CLK(CLK), .RST(RST), .bus(bus));
    typedef struct {
        logic        r, e, f, m;
        logic [11:0] t;
        logic [6:0]  d, u;
        int          n;
        logic [2:0]  st;
        logic [11:0] pw;
        logic        at;
        logic [15:0] mdu;
    } vec_t;
    vec_t vecs[$];
    int   applied = 0;
    int   miscompares = 0;
    bit   started = 0;
    logic last_rst, prev_b15;
    logic [11:0] prev_pw;
    function automatic void add(input logic r, e, f, m, input int t, d, u, n, st, pw, input logic at,
                                input logic [15:0] mdu);
        vec_t x;
        x.r = r; x.e = e; x.f = f; x.m = m;
        x.t = 12'(t); x.d = 7'(d); x.u = 7'(u); x.n = n;
        x.st = 3'(st); x.pw = 12'(pw); x.at = at; x.mdu = mdu;
        vecs.push_back(x);
    endfunction
    task automatic apply(input vec_t x, input int idx);
        RST = x.r; bus.ENABLE = x.e; bus.FAULT = x.f; bus.MOD_REQ = x.m;
        bus.TARGET = x.t; bus.DELAY_CFG = x.d; bus.UMIN_CFG = x.u;
        repeat (x.n) @(posedge CLK);
        #1;
        applied++;
        if (bus.STATE !== x.st || bus.POWER !== x.pw || bus.AT_TARGET !== x.at || bus.MOD_DELAY_UMIN !== x.mdu) begin
            miscompares++;
            $display("FAIL vec%0d: got state=%0d power=%0d at=%b mdu=%h, want state=%0d power=%0d at=%b mdu=%h",
                     idx, bus.STATE, bus.POWER, bus.AT_TARGET, bus.MOD_DELAY_UMIN, x.st, x.pw, x.at, x.mdu);
        end
    endtask
    task automatic wait_state(input logic [2:0] s, input int max, input string nm);
        int k = 0;
        while (bus.STATE !== s && k < max) begin
            @(posedge CLK);
            #1;
            k++;
        end
        applied++;
        if (bus.STATE !== s) begin
            miscompares++;
            $display("FAIL %s: state=%0d after %0d cycles, want %0d", nm, bus.STATE, k, s);
        end
    endtask
    // the modulation bit may only move while power is zero before and after (reset excepted)
    always @(posedge CLK) last_rst <= RST;
    always @(negedge CLK) begin
        if (started && !last_rst && bus.MOD_DELAY_UMIN[15] !== prev_b15) begin
            applied++;
            if (prev_pw !== 12'd0 || bus.POWER !== 12'd0) begin
                miscompares++;
                $display("FAIL mod_bit_change: power before=%0d after=%0d, want 0 and 0", prev_pw, bus.POWER);
            end
        end
        prev_b15 = bus.MOD_DELAY_UMIN[15];
        prev_pw  = bus.POWER;
    end
    initial begin
        //   r  e  f  m  tgt   dly   umn   n     st pw    at  mdu
        add(1, 0, 0, 1, 0,    'h25, 'h11, 2,    0, 0,    0, 16'hFF00);
        add(0, 0, 0, 1, 0,    'h25, 'h11, 1,    0, 0,    0, 16'hA522);
        add(0, 1, 0, 1, 40,   'h25, 'h11, 1,    1, 0,    0, 16'hA522);
        add(0, 1, 0, 1, 40,   'h25, 'h11, 4,    1, 16,   0, 16'hA522);
        add(0, 1, 0, 1, 40,   'h25, 'h11, 3,    1, 16,   0, 16'hA522);
        add(0, 1, 0, 1, 40,   'h25, 'h11, 1,    1, 32,   0, 16'hA522);
        add(0, 1, 0, 1, 40,   'h25, 'h11, 4,    1, 40,   0, 16'hA522);
        add(0, 1, 0, 1, 40,   'h25, 'h11, 1,    2, 40,   1, 16'hA522);
        add(0, 1, 0, 1, 40,   'h55, 'h11, 2,    2, 40,   1, 16'hA522);
        add(0, 0, 0, 1, 40,   'h55, 'h11, 1,    3, 40,   0, 16'hA522);
        add(0, 0, 0, 1, 40,   'h55, 'h11, 4,    3, 24,   0, 16'hA522);
        add(0, 0, 0, 1, 40,   'h55, 'h11, 4,    3, 8,    0, 16'hA522);
        add(0, 0, 0, 1, 40,   'h55, 'h11, 4,    3, 0,    0, 16'hA522);
        add(0, 0, 0, 1, 40,   'h55, 'h11, 1,    4, 0,    0, 16'hA522);
        add(0, 0, 0, 1, 40,   'h55, 'h11, 7,    4, 0,    0, 16'hD522);
        add(0, 0, 0, 1, 40,   'h55, 'h11, 1,    0, 0,    0, 16'hD522);
        add(0, 1, 0, 1, 40,   'h55, 'h11, 1,    1, 0,    0, 16'hD522);
        add(0, 1, 0, 1, 40,   'h55, 'h11, 13,   2, 40,   1, 16'hD522);
        add(0, 1, 0, 0, 40,   'h55, 'h11, 1,    3, 40,   0, 16'hD522);
        add(0, 1, 0, 0, 40,   'h55, 'h11, 12,   3, 0,    0, 16'hD522);
        add(0, 1, 0, 0, 40,   'h55, 'h11, 1,    4, 0,    0, 16'hD522);
        add(0, 1, 0, 0, 40,   'h55, 'h11, 7,    4, 0,    0, 16'hD522);
        add(0, 1, 0, 0, 40,   'h55, 'h11, 1,    1, 0,    0, 16'h5522);
        add(0, 1, 0, 0, 40,   'h55, 'h11, 13,   2, 40,   1, 16'h5522);
        add(0, 1, 0, 0, 100,  'h55, 'h11, 1,    1, 40,   0, 16'h5522);
        add(0, 1, 0, 0, 100,  'h55, 'h11, 4,    1, 56,   0, 16'h5522);
        add(1, 1, 0, 1, 40,   'h55, 'h11, 1,    0, 0,    0, 16'hFF00);
        add(0, 1, 0, 1, 40,   'h55, 'h11, 1,    1, 0,    0, 16'hD522);
        add(0, 1, 0, 1, 40,   'h55, 'h11, 8,    1, 32,   0, 16'hD522);
        add(0, 1, 1, 1, 40,   'h55, 'h11, 1,    5, 0,    0, 16'hD522);
        add(0, 1, 0, 1, 40,   'h55, 'h11, 3,    5, 0,    0, 16'hD522);
        add(0, 0, 0, 1, 40,   'h55, 'h11, 1,    0, 0,    0, 16'hD522);
        add(0, 1, 0, 0, 4095, 'h55, 'h11, 1,    4, 0,    0, 16'hD522);
        add(0, 1, 0, 0, 4095, 'h55, 'h11, 7,    4, 0,    0, 16'hD522);
        add(0, 1, 0, 0, 4095, 'h55, 'h11, 1,    1, 0,    0, 16'h5522);
        add(0, 1, 0, 0, 4095, 'h55, 'h11, 1020, 1, 4080, 0, 16'h5522);
        add(0, 1, 0, 0, 4095, 'h55, 'h11, 4,    1, 4095, 0, 16'h5522);
        add(0, 1, 0, 0, 4095, 'h55, 'h11, 1,    2, 4095, 1, 16'h5522);
        add(0, 1, 0, 0, 4095, 'h55, 'h11, 4,    2, 4095, 1, 16'h5522);
        add(0, 1, 0, 0, 4090, 'h55, 'h11, 1,    1, 4095, 0, 16'h5522);
        add(0, 1, 0, 0, 4090, 'h55, 'h11, 4,    1, 4090, 0, 16'h5522);
        add(0, 1, 0, 0, 4090, 'h55, 'h11, 1,    2, 4090, 1, 16'h5522);
        add(1, 1, 1, 0, 4090, 'h55, 'h11, 1,    0, 0,    0, 16'hFF00);
        add(0, 1, 1, 1, 4090, 'h55, 'h11, 1,    5, 0,    0, 16'hD522);
        foreach (vecs[i]) begin
            apply(vecs[i], i);
            if (i == 0) started = 1;
        end
        bus.FAULT = 1'b0;
        bus.ENABLE = 1'b0;
        wait_state(3'd0, 3, "fault_release");
        bus.ENABLE = 1'b1;
        bus.TARGET = 12'd40;
        bus.MOD_REQ = 1'b1;
        wait_state(3'd2, 30, "ramp_to_run");
        applied++;
        if (bus.POWER !== 12'd40 || bus.AT_TARGET !== 1'b1) begin
            miscompares++;
            $display("FAIL run_power: power=%0d at=%b, want power=40 at=1", bus.POWER, bus.AT_TARGET);
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
